// File: rtl/piano_pkg.sv
// Shared piano constants and the recorder state encoding; the auto-play side
// reads song memory using the same widths and terminator encoding.
package piano_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 26;
  localparam int ADDR_W = 5;

  localparam logic [NOTE_W-1:0] REST_NOTE     = '0;
  localparam logic [DUR_W-1:0]  TERM_DURATION = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_TRACK,
    ST_FLUSH,
    ST_TERM,
    ST_DONE
  } rec_state_t;

  // A released keyboard reads as a rest.
  function automatic logic [NOTE_W-1:0] eff_note(input logic on, input logic [NOTE_W-1:0] k);
    return on ? k : REST_NOTE;
  endfunction

endpackage

// File: rtl/record_segment_timer.sv
// Duration counter for the segment being tracked: clear loads 1 so the cycle a
// note first appears is counted, increment saturates at all-ones.
module record_segment_timer #(
  parameter int DUR_W     = 26,
  parameter int MIN_TICKS = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [DUR_W-1:0] count,
  output logic             ge_min
);

  localparam logic [DUR_W-1:0] CNT_MAX = '1;
  localparam logic [DUR_W-1:0] MIN_V   = DUR_W'(MIN_TICKS);

  // Clear wins over increment; saturate instead of wrapping on very long holds.
  always_ff @(posedge clk) begin
    if (!rst)                          count <= '0;
    else if (clr)                      count <= DUR_W'(1);
    else if (inc && count != CNT_MAX)  count <= count + DUR_W'(1);
  end

  assign ge_min = (count >= MIN_V);

endmodule

// File: rtl/record_mode.sv
// Song recorder: turns the live note stream into {note, duration} entries on
// the song memory write port, ending every session with a {0,0} terminator.
module record_mode
  import piano_pkg::*;
#(
  parameter int ADDR_W    = piano_pkg::ADDR_W,
  parameter int DUR_W     = piano_pkg::DUR_W,
  parameter int MIN_TICKS = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_on,
  input  logic [NOTE_W-1:0] key,
  input  logic              record_enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NOTE_W-1:0] wr_note,
  output logic [DUR_W-1:0]  wr_duration,
  output logic [ADDR_W-1:0] song_length,
  output logic              full,
  output logic              recording
);

  // Last slot is kept back for the terminator.
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  rec_state_t        state_q, state_d;
  logic              re_q;
  logic [NOTE_W-1:0] n, cur_note, cur_d;
  logic [ADDR_W-1:0] ptr_d, wr_addr_d;
  logic [NOTE_W-1:0] wr_note_d;
  logic [DUR_W-1:0]  wr_dur_d;
  logic              full_d, wr_en_d, recording_d;
  logic              t_clr, t_inc, seg_ok, seg_wr;
  logic [DUR_W-1:0]  count;
  logic              ge_min;

  assign n      = eff_note(key_on, key);
  assign seg_ok = ge_min && (song_length != PTR_LAST);

  record_segment_timer #(
    .DUR_W     (DUR_W),
    .MIN_TICKS (MIN_TICKS)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (t_clr),
    .inc    (t_inc),
    .count  (count),
    .ge_min (ge_min)
  );

  // Next state, segment close decisions and next write-port values.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_note;
    ptr_d     = song_length;
    full_d    = full;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_note_d = wr_note;
    wr_dur_d  = wr_duration;
    t_clr     = 1'b0;
    t_inc     = 1'b0;
    seg_wr    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (record_enable && !re_q) begin
          state_d = ST_WAIT_FIRST;
          ptr_d   = '0;
          full_d  = 1'b0;
        end
      end
      ST_WAIT_FIRST: begin
        // Leading rest is skipped; stopping here yields an empty song.
        if (!record_enable) state_d = ST_TERM;
        else if (n != REST_NOTE) begin
          cur_d   = n;
          t_clr   = 1'b1;
          state_d = ST_TRACK;
        end
      end
      ST_TRACK: begin
        // Stop beats a same-cycle note change: the new note is never started.
        if (!record_enable) state_d = ST_FLUSH;
        else if (n != cur_note) begin
          seg_wr = seg_ok;
          cur_d  = n;
          t_clr  = 1'b1;
        end else begin
          t_inc = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A trailing rest carries no music, so it is dropped.
        seg_wr  = seg_ok && (cur_note != REST_NOTE);
        state_d = ST_TERM;
      end
      ST_TERM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = song_length;
        wr_note_d = REST_NOTE;
        wr_dur_d  = DUR_W'(TERM_DURATION);
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (seg_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = song_length;
      wr_note_d = cur_note;
      wr_dur_d  = count;
      ptr_d     = song_length + ADDR_W'(1);
      full_d    = (ptr_d == PTR_LAST);
    end
  end

  assign recording_d = (state_d == ST_WAIT_FIRST) || (state_d == ST_TRACK) ||
                       (state_d == ST_FLUSH)      || (state_d == ST_TERM);

  // State, pointer and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      re_q        <= 1'b0;
      cur_note    <= REST_NOTE;
      song_length <= '0;
      full        <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_note     <= '0;
      wr_duration <= '0;
      recording   <= 1'b0;
    end else begin
      state_q     <= state_d;
      re_q        <= record_enable;
      cur_note    <= cur_d;
      song_length <= ptr_d;
      full        <= full_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_note     <= wr_note_d;
      wr_duration <= wr_dur_d;
      recording   <= recording_d;
    end
  end

endmodule

// File: tb/tb_record_mode.sv
// Bench for record_mode: sessions described as (key_on, key, length) pieces;
// the expected write list comes from the recording rules applied to merged
// effective-note segments, and is compared against every observed write.
module tb_record_mode;

  localparam int MIN = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  addr;
    logic [3:0]  note;
    logic [25:0] dur;
    logic [4:0]  sl;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_on;
  logic [3:0]  key;
  logic        record_enable;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_note;
  logic [25:0] wr_duration;
  logic [4:0]  song_length;
  logic        full;
  logic        recording;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t  mon_q[$];
  int   son[$], skey[$], slen[$];
  logic end_on;
  logic [3:0] end_key;

  record_mode #(.ADDR_W(5), .DUR_W(26), .MIN_TICKS(MIN)) dut (
    .clk(clk), .rst(rst), .key_on(key_on), .key(key),
    .record_enable(record_enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_note(wr_note), .wr_duration(wr_duration), .song_length(song_length),
    .full(full), .recording(recording)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write with the edge number that produced it.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t w;
      w.cyc = cyc; w.addr = wr_addr; w.note = wr_note; w.dur = wr_duration; w.sl = song_length;
      mon_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t mk(input int c, input int a, input int nt, input int d, input int s);
    wr_t w;
    w.cyc = c; w.addr = 5'(a); w.note = 4'(nt); w.dur = 26'(d); w.sl = 5'(s);
    return w;
  endfunction

  function automatic void add_piece(input logic on, input int k, input int len);
    son.push_back(int'(on)); skey.push_back(k); slen.push_back(len);
  endfunction

  // Drive one session from the piece lists, then check it against the rules.
  task automatic run_session(input string tag);
    int   st[$];
    int   rn[$], rs[$], rl[$];
    wr_t  exp_q[$];
    int   e, ptr, m, nt, lim;
    mon_q.delete();
    @(negedge clk);
    record_enable = 1'b1; key_on = 1'b0; key = 4'($urandom_range(0, 15));
    repeat (2) @(negedge clk);
    chk({tag, "/recording_on"}, recording, 1);
    for (int i = 0; i < son.size(); i++) begin
      key_on = son[i][0];
      key    = 4'(skey[i]);
      st.push_back(cyc + 1);
      repeat (slen[i]) @(negedge clk);
    end
    record_enable = 1'b0; key_on = end_on; key = end_key;
    e = cyc + 1;
    repeat (6) @(negedge clk);
    // Merge equal effective notes into segments, dropping the leading rest.
    for (int i = 0; i < son.size(); i++) begin
      nt = (son[i] != 0) ? skey[i] : 0;
      if (rn.size() == 0 && nt == 0) continue;
      if (rn.size() > 0 && rn[rn.size()-1] == nt) rl[rl.size()-1] += slen[i];
      else begin rn.push_back(nt); rs.push_back(st[i]); rl.push_back(slen[i]); end
    end
    m = rn.size();
    ptr = 0;
    for (int j = 0; j < m - 1; j++)
      if (rl[j] >= MIN && ptr < 31) begin
        exp_q.push_back(mk(rs[j] + rl[j], ptr, rn[j], rl[j], ptr + 1));
        ptr++;
      end
    if (m > 0 && rn[m-1] != 0 && rl[m-1] >= MIN && ptr < 31) begin
      exp_q.push_back(mk(e + 1, ptr, rn[m-1], rl[m-1], ptr + 1));
      ptr++;
    end
    exp_q.push_back(mk((m > 0) ? e + 2 : e + 1, ptr, 0, 0, ptr));
    chk({tag, "/num_writes"}, mon_q.size(), exp_q.size());
    lim = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int k = 0; k < lim; k++)
      chk($sformatf("%s/write%0d{cyc,addr,note,dur,len}", tag, k), mon_q[k], exp_q[k]);
    chk({tag, "/song_length"}, song_length, ptr);
    chk({tag, "/full"}, full, (ptr == 31) ? 1 : 0);
    chk({tag, "/recording_off"}, recording, 0);
    son.delete(); skey.delete(); slen.delete();
  endtask

  initial begin
    rst = 1'b0; record_enable = 1'b0; key_on = 1'b0; key = 4'd0;
    end_on = 1'b0; end_key = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wr_en, wr_addr, wr_note, wr_duration, song_length, full, recording}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic session.
    add_piece(1, 3, 10); add_piece(0, 9, 6); add_piece(1, 5, 8);
    end_on = 1'b0; end_key = 4'd0;
    run_session("basic");

    // Short first note and trailing rest are both dropped.
    add_piece(1, 2, 3); add_piece(1, 4, 9); add_piece(0, 0, 20);
    run_session("drops");

    // No keys at all.
    run_session("empty");

    // 40 alternating notes overflow the memory.
    for (int i = 0; i < 40; i++) add_piece(1, (i % 2 == 0) ? 5 : 6, 5);
    run_session("overflow");

    // Stop and 3->6 change on the same edge; pressed key 0 also acts as a rest.
    add_piece(1, 0, 5); add_piece(1, 3, 7);
    end_on = 1'b1; end_key = 4'd6;
    run_session("simultaneous");

    // Randomized sessions.
    for (int r = 0; r < 5; r++) begin
      int ns;
      ns = $urandom_range(3, 14);
      for (int i = 0; i < ns; i++)
        add_piece(($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(1, 8));
      end_on = 1'($urandom_range(0, 1)); end_key = 4'($urandom_range(0, 15));
      run_session($sformatf("random%0d", r));
    end

    // Reset while tracking a held note.
    mon_q.delete();
    @(negedge clk);
    record_enable = 1'b1; key_on = 1'b0;
    repeat (2) @(negedge clk);
    key_on = 1'b1; key = 4'd7;
    repeat (10) @(negedge clk);
    rst = 1'b0; record_enable = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {wr_en, wr_addr, wr_note, wr_duration, song_length, full, recording}, 0);
    rst = 1'b1; key_on = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_no_writes", mon_q.size(), 0);
    add_piece(1, 9, 6); add_piece(1, 1, 4);
    end_on = 1'b0; end_key = 4'd0;
    run_session("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/record_mode.md
# record_mode

Song recorder for the piano: watches the live keyboard note stream and writes {note, duration} entries into song memory, in the same format the auto-play path reads back. Sits between the free-play keyboard decoder and the song memory write port. Each held note or rest becomes one entry, and every recording ends with a terminator entry. Auto-play then replays the memory from address 0.

## Interface
Parameters:
- ADDR_W, 5, song memory address width; depth = 2^ADDR_W = 32 entries
- DUR_W, 26, duration width in clk cycles
- MIN_TICKS, 1_000_000, shortest segment kept (10 ms at 100 MHz); shorter segments are discarded

Ports:
- clk  in  1  system clock; the block has one clock
- rst  in  1  reset, synchronous and active-low
- key_on  in  1  a key is pressed
- key  in  4  note value of the pressed key; ignored when key_on=0
- record_enable  in  1  level; 1 = recording session active
- wr_en  out  1  one-cycle memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_note  out  4  note written; 0 = rest / terminator
- wr_duration  out  DUR_W  duration written, in clk cycles
- song_length  out  ADDR_W  note/rest entries written this session, excluding the terminator
- full  out  1  memory full; later segments are dropped
- recording  out  1  high in WAIT_FIRST, TRACK, FLUSH and TERM; drives the status LED

## Operation
- Effective note: n = key_on ? key : 0. key_on=1 with key=0 counts as a rest.
- States are IDLE, WAIT_FIRST, TRACK, FLUSH, TERM and DONE.
- IDLE/DONE → WAIT_FIRST on a rising edge of record_enable (registered previous value). On entry: ptr=0, song_length=0, full=0.
- WAIT_FIRST: leading rest is not recorded.
  - When n≠0: cur_note=n, count=1, go to TRACK.
  - If record_enable=0: go to TERM. This gives an empty song, with the terminator at address 0.
- TRACK: count increments each cycle and saturates at 2^DUR_W−1. When n≠cur_note, the segment {cur_note, count} closes:
  - Written at ptr only if count ≥ MIN_TICKS and ptr < 2^ADDR_W−1; then ptr and song_length increment.
  - If not written, the segment is discarded.
  - In both cases cur_note=n and count=1.
  - Rest segments (cur_note=0) are written like notes.
- full rises when ptr reaches 2^ADDR_W−1 (31). The last slot is reserved for the terminator.
- TRACK → FLUSH when record_enable=0. This takes priority over a note change in the same cycle: the new note is ignored and the current segment is flushed.
- FLUSH: writes {cur_note, count} under the same rules, except a trailing rest (cur_note=0) is never written. Then go to TERM.
- TERM: writes {0, 0} at ptr unconditionally. Then go to DONE.
- DONE: holds song_length and full until the next session starts.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_note=0, wr_duration=0, song_length=0, full=0, recording=0; state=IDLE.
- Reset mid-session aborts without writing anything. Memory contents are not cleared; the block does not own them.
- All outputs are registered.
- Segment close: the change is seen on rising edge k and wr_en is high during cycle k+1. wr_addr/wr_note/wr_duration are valid only while wr_en=1 and hold their last values otherwise.
- Duration counts cycles, including the cycle where the note first appears. A note present on edges k…k+D−1 is written with duration D.
- Session stop: FLUSH write (if any) is 1 cycle after the record_enable fall is seen. TERM write is the next cycle. recording falls when DONE is entered.
- At most one wr_en per cycle, so back-to-back writes are allowed.
- song_length updates in the same cycle as its wr_en.
- record_enable re-asserted while in FLUSH or TERM is ignored. A new session needs a fresh rising edge seen in IDLE or DONE.

## Structure
- Shared package piano_pkg holds:
  - NOTE_W=4, DUR_W=26, ADDR_W=5
  - REST_NOTE=0
  - TERM_DURATION=0
  - the record state enum
- The auto-play side uses the same package constants.
- One sub-module, record_segment_timer: a saturating duration counter with clear-to-1 and a `count ≥ MIN_TICKS` flag.
- The FSM, pointer and write-port registers live in record_mode.

## Test plan
MIN_TICKS=4 for the bench.
- Basic session: enable; note 3 for 10 cycles; rest 6 cycles; note 5 for 8 cycles; disable → writes {3,10}@0, {0,6}@1, {5,8}@2, {0,0}@3; song_length=3.
- Short-segment and trailing-rest drops: note 2 for 3 cycles, then note 4 for 9 cycles, then rest 20 cycles, disable → {4,9}@0, {0,0}@1; the note-2 segment and the trailing rest are not written.
- Empty session: enable then disable with no keys pressed → single write {0,0}@0; song_length=0.
- Overflow: 40 alternating notes of 5 cycles each → entries 0–30 written; full=1 after the write at 30; no wr_en during the remaining notes; terminator at 31; song_length=31.
- Simultaneous events: record_enable falls in the same cycle key changes 3→6 → {3,D}, then {0,0}; note 6 is never written.
- Reset mid-TRACK: assert rst during a held note → no further wr_en and all outputs 0 next cycle; a following enable restarts at address 0.
